// File: rtl/param_cmd_sender_pkg.sv
// Shared definitions for the parameter command path: opcode and FSM encodings,
// legality limits and the command payload struct. Also used by parameter_generator.
package param_cmd_sender_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NUM_ACK = 6;

    typedef enum logic [OP_W-1:0] {
        OP_START    = 3'd0,
        OP_STOP     = 3'd1,
        OP_TON      = 3'd2,
        OP_TOFF     = 3'd3,
        OP_IP       = 3'd4,
        OP_WAVEFORM = 3'd5,
        OP_RSVD6    = 3'd6,
        OP_RSVD7    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] IP_MAX = 16'd80;
    localparam logic [DATA_W-1:0] WAVE_A = 16'h8000;
    localparam logic [DATA_W-1:0] WAVE_B = 16'h0001;
    localparam logic [DATA_W-1:0] WAVE_C = 16'h0002;

    typedef struct packed {
        opcode_e             opcode;
        logic [DATA_W-1:0]   data;
    } cmd_t;

    // One-hot ack vector for an opcode; bit order follows the opcode values.
    function automatic logic [NUM_ACK-1:0] ack_onehot(input opcode_e op);
        logic [NUM_ACK-1:0] v;
        v = '0;
        case (op)
            OP_START:    v[0] = 1'b1;
            OP_STOP:     v[1] = 1'b1;
            OP_TON:      v[2] = 1'b1;
            OP_TOFF:     v[3] = 1'b1;
            OP_IP:       v[4] = 1'b1;
            OP_WAVEFORM: v[5] = 1'b1;
            default:     v    = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/param_validator.sv
// Combinational legality check of a host command.
//   cmd     : opcode + parameter value
//   legal_c : high when the command may be sent to the discharge controller
module param_validator
    import param_cmd_sender_pkg::*;
(
    input  cmd_t cmd,
    output logic legal_c
);

    always_comb begin
        legal_c = 1'b0;
        case (cmd.opcode)
            OP_START, OP_STOP: legal_c = 1'b1;
            OP_TON, OP_TOFF:   legal_c = (cmd.data != '0);
            OP_IP:             legal_c = (cmd.data != '0) && (cmd.data <= IP_MAX);
            OP_WAVEFORM:       legal_c = (cmd.data == WAVE_A) || (cmd.data == WAVE_B) ||
                                         (cmd.data == WAVE_C);
            default:           legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/param_cmd_sender.sv
// Serializes host parameter commands into setup / ack-pulse / hold handshakes
// towards the discharge controller.
//   clk, rst_n            : clock, async active-low reset
//   cmd_valid/cmd_ready   : host handshake; cmd_opcode/cmd_data carry the command
//   *_ack                 : one registered ack pulse per accepted command
//   *_data_async          : registered parameter buses, loaded at accept
//   cmd_error             : one-cycle pulse after a rejected command
//   busy                  : FSM not idle
module param_cmd_sender
    import param_cmd_sender_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned ACK_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              machine_start_ack,
    output logic              machine_stop_ack,
    output logic              change_Ton_ack,
    output logic              change_Toff_ack,
    output logic              change_Ip_ack,
    output logic              change_waveform_ack,
    output logic [DATA_W-1:0] Ton_data_async,
    output logic [DATA_W-1:0] Toff_data_async,
    output logic [DATA_W-1:0] Ip_data_async,
    output logic [DATA_W-1:0] waveform_data_async,
    output logic              cmd_error,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LD   = CNT_W'(ACK_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cmd_t               cmd;
    logic               legal_c;
    logic               accept;
    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    opcode_e            op_q;

    logic [NUM_ACK-1:0] ack_q, ack_nxt;
    logic               err_nxt, busy_nxt;
    logic               ton_ld, toff_ld, ip_ld, wave_ld;

    assign cmd       = '{opcode: opcode_e'(cmd_opcode), data: cmd_data};
    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    param_validator u_validator (
        .cmd     (cmd),
        .legal_c (legal_c)
    );

    // State register, phase counter and latched opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_START;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && legal_c) begin
                op_q <= cmd.opcode;
            end
        end
    end

    // Next state: each phase loads its length on entry and leaves when the count hits 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept && legal_c) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt <= CNT_ONE) begin
                    state_nxt = ST_ACK;
                    cnt_nxt   = ACK_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_ACK: begin
                if (cnt <= CNT_ONE) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLD_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt <= CNT_ONE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        ack_nxt  = '0;
        err_nxt  = 1'b0;
        busy_nxt = (state_nxt != ST_IDLE);
        ton_ld   = 1'b0;
        toff_ld  = 1'b0;
        ip_ld    = 1'b0;
        wave_ld  = 1'b0;
        if (state_nxt == ST_ACK) begin
            ack_nxt = ack_onehot(op_q);
        end
        if (accept) begin
            err_nxt = !legal_c;
            ton_ld  = legal_c && (cmd.opcode == OP_TON);
            toff_ld = legal_c && (cmd.opcode == OP_TOFF);
            ip_ld   = legal_c && (cmd.opcode == OP_IP);
            wave_ld = legal_c && (cmd.opcode == OP_WAVEFORM);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q               <= '0;
            cmd_error           <= 1'b0;
            busy                <= 1'b0;
            Ton_data_async      <= '0;
            Toff_data_async     <= '0;
            Ip_data_async       <= '0;
            waveform_data_async <= '0;
        end else begin
            ack_q     <= ack_nxt;
            cmd_error <= err_nxt;
            busy      <= busy_nxt;
            if (ton_ld)  Ton_data_async      <= cmd.data;
            if (toff_ld) Toff_data_async     <= cmd.data;
            if (ip_ld)   Ip_data_async       <= cmd.data;
            if (wave_ld) waveform_data_async <= cmd.data;
        end
    end

    assign machine_start_ack   = ack_q[0];
    assign machine_stop_ack    = ack_q[1];
    assign change_Ton_ack      = ack_q[2];
    assign change_Toff_ack     = ack_q[3];
    assign change_Ip_ack       = ack_q[4];
    assign change_waveform_ack = ack_q[5];

endmodule
